// File: rtl/auv_pkg.sv
// Shared definitions for the AUV decode stage: opcodes, instruction field
// positions, the decoded-instruction record and immediate sign-extension helpers.
package auv_pkg;

  localparam int XLEN  = 32;
  localparam int OP_W  = 6;
  localparam int REG_W = 4;
  localparam int NREGS = 16;

  localparam logic [OP_W-1:0] OP_NOP  = 6'd0;
  localparam logic [OP_W-1:0] OP_ALU  = 6'd1;
  localparam logic [OP_W-1:0] OP_ALUI = 6'd2;
  localparam logic [OP_W-1:0] OP_LD   = 6'd3;
  localparam logic [OP_W-1:0] OP_ST   = 6'd4;
  localparam logic [OP_W-1:0] OP_BR   = 6'd5;
  localparam logic [OP_W-1:0] OP_JAL  = 6'd6;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RD_MSB  = 25;
  localparam int RD_LSB  = 22;
  localparam int RS0_MSB = 21;
  localparam int RS0_LSB = 18;
  localparam int RS1_MSB = 17;
  localparam int RS1_LSB = 14;
  localparam int IMM14_W = 14;
  localparam int IMM22_W = 22;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] rd;
    logic             we;
    logic [REG_W-1:0] rs0;
    logic [REG_W-1:0] rs1;
    logic             use0;
    logic             use1;
    logic [XLEN-1:0]  imm;
    logic             illegal;
  } decoded_t;

  function automatic logic signed [XLEN-1:0] sext14(input logic [IMM14_W-1:0] v);
    return {{(XLEN-IMM14_W){v[IMM14_W-1]}}, v};
  endfunction

  function automatic logic signed [XLEN-1:0] sext22(input logic [IMM22_W-1:0] v);
    return {{(XLEN-IMM22_W){v[IMM22_W-1]}}, v};
  endfunction

endpackage

// File: rtl/auv_decode_fields.sv
// Combinational instruction-word to decoded_t mapping.
// AUV_ILLEGAL_OP_EN: flag opcodes 7-63 as illegal instead of decoding them as NOP.
module auv_decode_fields
  import auv_pkg::*;
(
  input  logic [XLEN-1:0] instr_i,
  output decoded_t        dec_o
);

  logic [OP_W-1:0]  op;
  logic [REG_W-1:0] rd;
  logic             use0;
  logic             use1;
  logic             writes;
  logic             illegal;
  logic [OP_W-1:0]  op_out;
  logic [XLEN-1:0]  imm;

  always_comb begin
    op      = instr_i[OP_MSB:OP_LSB];
    rd      = instr_i[RD_MSB:RD_LSB];
    use0    = 1'b0;
    use1    = 1'b0;
    writes  = 1'b0;
    illegal = 1'b0;
    op_out  = op;
    imm     = sext14(instr_i[IMM14_W-1:0]);
    case (op)
      OP_NOP:  ;
      OP_ALU:  begin use0 = 1'b1; use1 = 1'b1; writes = 1'b1; end
      OP_ALUI: begin use0 = 1'b1; writes = 1'b1; end
      OP_LD:   begin use0 = 1'b1; writes = 1'b1; end
      OP_ST:   begin use0 = 1'b1; use1 = 1'b1; end
      OP_BR:   begin use0 = 1'b1; use1 = 1'b1; end
      OP_JAL:  begin writes = 1'b1; imm = sext22(instr_i[IMM22_W-1:0]); end
      default: begin
`ifdef AUV_ILLEGAL_OP_EN
        illegal = 1'b1;
`else
        op_out  = OP_NOP;
`endif
      end
    endcase
  end

  // Unused sources read r0, which is never busy, so they cannot raise a hazard.
  always_comb begin
    dec_o         = '0;
    dec_o.op      = op_out;
    dec_o.rd      = rd;
    dec_o.we      = writes & (rd != '0);
    dec_o.rs0     = use0 ? instr_i[RS0_MSB:RS0_LSB] : '0;
    dec_o.rs1     = use1 ? instr_i[RS1_MSB:RS1_LSB] : '0;
    dec_o.use0    = use0;
    dec_o.use1    = use1;
    dec_o.imm     = imm;
    dec_o.illegal = illegal;
  end

endmodule

// File: rtl/auv_decode.sv
// AUV instruction-decode stage: register-file address drive, RAW/WAW scoreboard,
// decode pipeline register and valid/ready handoff to execute. Macro: AUV_ILLEGAL_OP_EN.
module auv_decode
  import auv_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [XLEN-1:0]  if_instr,
  input  logic [XLEN-1:0]  if_pc,
  output logic             if_ready,
  output logic [REG_W-1:0] rf_ra0,
  output logic [REG_W-1:0] rf_ra1,
  output logic             rf_stall,
  input  logic             wb_we,
  input  logic [REG_W-1:0] wb_wa,
  input  logic             flush,
  input  logic             ex_ready,
  output logic             id_valid,
  output logic [OP_W-1:0]  id_op,
  output logic [REG_W-1:0] id_rd,
  output logic             id_we,
  output logic [XLEN-1:0]  id_imm,
  output logic [XLEN-1:0]  id_pc,
  output logic             id_illegal
);

  decoded_t dec;

  logic [NREGS-1:0] busy_q, busy_d;
  logic             id_valid_q;
  logic [OP_W-1:0]  id_op_q;
  logic [REG_W-1:0] id_rd_q;
  logic             id_we_q;
  logic [XLEN-1:0]  id_imm_q;
  logic [XLEN-1:0]  id_pc_q;
  logic             id_illegal_q;

  logic haz_rs0, haz_rs1, haz_waw, hazard, hold, accept;

  auv_decode_fields u_fields (
    .instr_i (if_instr),
    .dec_o   (dec)
  );

  assign rf_ra0 = dec.rs0;
  assign rf_ra1 = dec.rs1;

  // A register being written back this cycle is forwarded by the register file,
  // so its busy bit does not block a reader or a new writer.
  assign haz_rs0 = dec.use0 & busy_q[dec.rs0] & ~(wb_we & (wb_wa == dec.rs0));
  assign haz_rs1 = dec.use1 & busy_q[dec.rs1] & ~(wb_we & (wb_wa == dec.rs1));
  assign haz_waw = dec.we   & busy_q[dec.rd]  & ~(wb_we & (wb_wa == dec.rd));
  assign hazard  = haz_rs0 | haz_rs1 | haz_waw;

  assign hold     = id_valid_q & ~ex_ready;
  assign if_ready = ~hold & ~hazard & ~flush;
  assign accept   = if_valid & if_ready;
  assign rf_stall = ~accept;

  // Later steps win: a set of the accepted rd overrides any clear of the same index.
  always_comb begin
    busy_d = busy_q;
    if (wb_we)
      busy_d[wb_wa] = 1'b0;
    if (flush && id_valid_q && id_we_q)
      busy_d[id_rd_q] = 1'b0;
    if (accept && dec.we)
      busy_d[dec.rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Decode -> execute stage boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q       <= '0;
      id_valid_q   <= 1'b0;
      id_op_q      <= '0;
      id_rd_q      <= '0;
      id_we_q      <= 1'b0;
      id_imm_q     <= '0;
      id_pc_q      <= '0;
      id_illegal_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      if (accept) begin
        id_valid_q   <= 1'b1;
        id_op_q      <= dec.op;
        id_rd_q      <= dec.rd;
        id_we_q      <= dec.we;
        id_imm_q     <= dec.imm;
        id_pc_q      <= if_pc;
        id_illegal_q <= dec.illegal;
      end else if (flush || ex_ready) begin
        id_valid_q <= 1'b0;
      end
    end
  end

  assign id_valid   = id_valid_q;
  assign id_op      = id_op_q;
  assign id_rd      = id_rd_q;
  assign id_we      = id_we_q;
  assign id_imm     = id_imm_q;
  assign id_pc      = id_pc_q;
  assign id_illegal = id_illegal_q;

endmodule

// File: tb/tb_auv_decode.sv
// Self-checking bench for auv_decode: table of single instructions plus
// hand-written hazard, flush, hold and reset sequences, checked via a scoreboard queue.
module tb_auv_decode;
  import auv_pkg::*;

  logic        clk, rst;
  logic        if_valid;
  logic [31:0] if_instr, if_pc;
  logic        if_ready;
  logic [3:0]  rf_ra0, rf_ra1;
  logic        rf_stall;
  logic        wb_we;
  logic [3:0]  wb_wa;
  logic        flush, ex_ready;
  logic        id_valid;
  logic [5:0]  id_op;
  logic [3:0]  id_rd;
  logic        id_we;
  logic [31:0] id_imm, id_pc;
  logic        id_illegal;

  auv_decode dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_ready(if_ready), .rf_ra0(rf_ra0), .rf_ra1(rf_ra1), .rf_stall(rf_stall),
    .wb_we(wb_we), .wb_wa(wb_wa), .flush(flush), .ex_ready(ex_ready),
    .id_valid(id_valid), .id_op(id_op), .id_rd(id_rd), .id_we(id_we),
    .id_imm(id_imm), .id_pc(id_pc), .id_illegal(id_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [5:0]  op;
    logic [3:0]  rd;
    logic        we;
    logic [31:0] imm;
    logic        ill;
  } id_exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [3:0]  ra0;
    logic [3:0]  ra1;
    logic [5:0]  op;
    logic [3:0]  rd;
    logic        we;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  id_exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs0, input logic [3:0] rs1,
                                      input logic [13:0] imm);
    return {op, rd, rs0, rs1, imm};
  endfunction

  // Reference decode of the fields execute sees.
  function automatic id_exp_t model(input logic [31:0] instr, input logic [31:0] pc);
    id_exp_t e;
    logic [5:0] op;
    logic known, wcls;
    op    = instr[31:26];
    known = (op <= 6'd6);
    wcls  = (op == 6'd1) || (op == 6'd2) || (op == 6'd3) || (op == 6'd6);
    e.pc  = pc;
    e.rd  = instr[25:22];
    e.imm = (op == 6'd6) ? {{10{instr[21]}}, instr[21:0]} : {{18{instr[13]}}, instr[13:0]};
    e.we  = known && wcls && (instr[25:22] != 4'd0);
`ifdef AUV_ILLEGAL_OP_EN
    e.op  = op;
    e.ill = !known;
`else
    e.op  = known ? op : 6'd0;
    e.ill = 1'b0;
`endif
    return e;
  endfunction

  task automatic check_id(input string tag);
    id_exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q[0];
      chk({tag, "_id_valid"}, id_valid, 1);
      chk({tag, "_id_op"}, id_op, e.op);
      chk({tag, "_id_rd"}, id_rd, e.rd);
      chk({tag, "_id_we"}, id_we, e.we);
      chk({tag, "_id_imm"}, id_imm, e.imm);
      chk({tag, "_id_pc"}, id_pc, e.pc);
      chk({tag, "_id_illegal"}, id_illegal, e.ill);
    end else begin
      chk({tag, "_id_valid_idle"}, id_valid, 0);
    end
  endtask

  // Check handshake outputs, update scoreboard, advance one clock and check id_*.
  task automatic step_e(input bit exp_ready, input string tag, input bit use_ovr,
                        input id_exp_t ovr);
    bit acc;
    chk({tag, "_if_ready"}, if_ready, exp_ready);
    acc = if_valid && exp_ready;
    chk({tag, "_rf_stall"}, rf_stall, !acc);
    if ((ex_ready || flush) && exp_q.size() > 0) void'(exp_q.pop_front());
    if (acc) exp_q.push_back(use_ovr ? ovr : model(if_instr, if_pc));
    @(posedge clk);
    #1;
    check_id(tag);
  endtask

  task automatic step(input bit exp_ready, input string tag);
    id_exp_t dummy;
    dummy = '{default: '0};
    step_e(exp_ready, tag, 1'b0, dummy);
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    if_valid = v;
    if_instr = instr;
    if_pc    = pc;
    #1;
  endtask

  vec_t tv[9];

  initial begin
    id_exp_t e;
    rst = 1'b1; if_valid = 0; if_instr = '0; if_pc = '0;
    wb_we = 0; wb_wa = '0; flush = 0; ex_ready = 1;

    tv[0] = '{enc(6'd0, 4'd5, 4'd3, 4'd4, 14'h0010), 32'h100, 4'd0, 4'd0, 6'd0, 4'd5, 1'b0, 32'h00000010, 1'b0};
    tv[1] = '{enc(6'd1, 4'd1, 4'd2, 4'd3, 14'h3FFF), 32'h104, 4'd2, 4'd3, 6'd1, 4'd1, 1'b1, 32'hFFFFFFFF, 1'b0};
    tv[2] = '{enc(6'd2, 4'd4, 4'd5, 4'd7, 14'h2000), 32'h108, 4'd5, 4'd0, 6'd2, 4'd4, 1'b1, 32'hFFFFE000, 1'b0};
    tv[3] = '{enc(6'd3, 4'd7, 4'd8, 4'd0, 14'h1FFF), 32'h10C, 4'd8, 4'd0, 6'd3, 4'd7, 1'b1, 32'h00001FFF, 1'b0};
    tv[4] = '{enc(6'd4, 4'd9, 4'd10, 4'd11, 14'h0004), 32'h110, 4'd10, 4'd11, 6'd4, 4'd9, 1'b0, 32'h00000004, 1'b0};
    tv[5] = '{enc(6'd5, 4'd0, 4'd12, 4'd13, 14'h3FF0), 32'h114, 4'd12, 4'd13, 6'd5, 4'd0, 1'b0, 32'hFFFFFFF0, 1'b0};
    tv[6] = '{{6'd6, 4'd14, 22'h200000}, 32'h118, 4'd0, 4'd0, 6'd6, 4'd14, 1'b1, 32'hFFE00000, 1'b0};
    tv[7] = '{enc(6'd1, 4'd0, 4'd1, 4'd2, 14'h0001), 32'h11C, 4'd1, 4'd2, 6'd1, 4'd0, 1'b0, 32'h00000001, 1'b0};
`ifdef AUV_ILLEGAL_OP_EN
    tv[8] = '{enc(6'h3F, 4'd3, 4'd2, 4'd1, 14'h0002), 32'h120, 4'd0, 4'd0, 6'h3F, 4'd3, 1'b0, 32'h00000002, 1'b1};
`else
    tv[8] = '{enc(6'h3F, 4'd3, 4'd2, 4'd1, 14'h0002), 32'h120, 4'd0, 4'd0, 6'h00, 4'd3, 1'b0, 32'h00000002, 1'b0};
`endif

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_id_valid", id_valid, 0);
    chk("rst_id_op", id_op, 0);
    chk("rst_id_imm", id_imm, 0);
    chk("rst_id_pc", id_pc, 0);
    chk("rst_id_illegal", id_illegal, 0);
    chk("rst_busy", dut.busy_q, 0);

    // Table: each vector accepted alone, then its destination is written back.
    for (int i = 0; i < 9; i++) begin
      drive(1, tv[i].instr, tv[i].pc);
      chk($sformatf("tv%0d_ra0", i), rf_ra0, tv[i].ra0);
      chk($sformatf("tv%0d_ra1", i), rf_ra1, tv[i].ra1);
      e = '{tv[i].pc, tv[i].op, tv[i].rd, tv[i].we, tv[i].imm, tv[i].ill};
      step_e(1, $sformatf("tv%0d", i), 1'b1, e);
      chk($sformatf("tv%0d_busy", i), dut.busy_q, tv[i].we ? (32'h1 << tv[i].rd) : 32'h0);
      wb_we = 1; wb_wa = tv[i].rd;
      drive(0, 32'h0, 32'h0);
      step(1, $sformatf("tv%0d_wb", i));
      wb_we = 0;
    end
    chk("tv_busy_end", dut.busy_q, 0);

    // Independent instructions back to back
    drive(1, enc(6'd1, 4'd1, 4'd2, 4'd3, 14'h0), 32'h200);
    chk("ind_ra0_a", rf_ra0, 2); chk("ind_ra1_a", rf_ra1, 3);
    step(1, "ind_a");
    drive(1, enc(6'd2, 4'd4, 4'd5, 4'd0, 14'h5), 32'h204);
    chk("ind_ra0_b", rf_ra0, 5); chk("ind_ra1_b", rf_ra1, 0);
    step(1, "ind_b");
    chk("ind_busy", dut.busy_q, 32'h0012);
    wb_we = 1; wb_wa = 4'd1; drive(0, 32'h0, 32'h0); step(1, "ind_wb1");
    wb_wa = 4'd4; #1; step(1, "ind_wb4");
    wb_we = 0;
    chk("ind_busy_clr", dut.busy_q, 0);

    // RAW hazard on r1, released by same-cycle write-back
    drive(1, enc(6'd1, 4'd1, 4'd2, 4'd3, 14'h0), 32'h300);
    step(1, "raw_a");
    drive(1, enc(6'd1, 4'd6, 4'd1, 4'd2, 14'h0), 32'h304);
    chk("raw_ra0", rf_ra0, 1);
    step(0, "raw_stall0");
    step(0, "raw_stall1");
    wb_we = 1; wb_wa = 4'd1; #1;
    step(1, "raw_wb");
    wb_we = 0;
    chk("raw_busy", dut.busy_q, 32'h0040);
    wb_we = 1; wb_wa = 4'd6; drive(0, 32'h0, 32'h0); step(1, "raw_clr");
    wb_we = 0;

    // WAW hazard on r7; r0 destination never stalls nor marks busy
    drive(1, enc(6'd3, 4'd7, 4'd2, 4'd0, 14'h8), 32'h400);
    step(1, "waw_ld");
    drive(1, {6'd6, 4'd7, 22'h000005}, 32'h404);
    step(0, "waw_stall0");
    step(0, "waw_stall1");
    wb_we = 1; wb_wa = 4'd7; #1;
    step(1, "waw_wb");
    wb_we = 0;
    chk("waw_busy", dut.busy_q, 32'h0080);
    drive(1, enc(6'd1, 4'd0, 4'd2, 4'd3, 14'h0), 32'h408);
    step(1, "waw_r0");
    chk("waw_r0_busy", dut.busy_q, 32'h0080);
    wb_we = 1; wb_wa = 4'd7; drive(0, 32'h0, 32'h0); step(1, "waw_clr");
    wb_we = 0;

    // Flush while execute stalls
    drive(1, enc(6'd2, 4'd9, 4'd2, 4'd0, 14'h1), 32'h500);
    step(1, "fl_a");
    chk("fl_busy_set", dut.busy_q, 32'h0200);
    ex_ready = 0; flush = 1;
    drive(1, enc(6'd1, 4'd10, 4'd2, 4'd3, 14'h0), 32'h504);
    step(0, "fl_cyc");
    flush = 0; ex_ready = 1;
    chk("fl_busy_clr", dut.busy_q, 0);

    // Hold: execute not ready for three cycles
    drive(1, enc(6'd1, 4'd11, 4'd2, 4'd3, 14'h7), 32'h600);
    step(1, "hold_a");
    ex_ready = 0;
    drive(1, enc(6'd2, 4'd12, 4'd5, 4'd0, 14'h9), 32'h604);
    for (int k = 0; k < 3; k++) step(0, $sformatf("hold%0d", k));
    ex_ready = 1; #1;
    step(1, "hold_rel");
    wb_we = 1; wb_wa = 4'd11; drive(0, 32'h0, 32'h0); step(1, "hold_wb11");
    wb_wa = 4'd12; #1; step(1, "hold_wb12");
    wb_we = 0;
    chk("hold_busy", dut.busy_q, 0);

    // Asynchronous reset mid-stream
    drive(1, enc(6'd1, 4'd5, 4'd2, 4'd3, 14'h0), 32'h700);
    step(1, "rs_a");
    chk("rs_busy_pre", dut.busy_q, 32'h0020);
    #2 rst = 1'b1;
    #1;
    chk("rs_id_valid", id_valid, 0);
    chk("rs_id_we", id_we, 0);
    chk("rs_busy", dut.busy_q, 0);
    exp_q.delete();
    if_valid = 0;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("rs_after_valid", id_valid, 0);
    drive(1, enc(6'd1, 4'd6, 4'd5, 4'd2, 14'h0), 32'h704);
    chk("rs_after_ready", if_ready, 1);
    if_valid = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
